// File: rtl/unit_responder.sv
// Command-driven unit: decodes controller packets addressed to this unit and runs
// multi-beat LOAD/STORE transfers or a handshaked COMPUTE, reporting busy cycle count.
package unit_responder_pkg;

    typedef struct packed {
        logic [5:0] encoded_control;  // [5:4] unit id, [3:2] op, [1:0] compute type
        logic [7:0] data_control;     // [7:4] base addr, [3] valid, [2:0] size
    } control_packet_t;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_LOAD    = 2'b01,
        OP_STORE   = 2'b10,
        OP_COMPUTE = 2'b11
    } op_e;

endpackage

module unit_responder
    import unit_responder_pkg::*;
#(
    parameter logic [1:0]  UNIT_ID = 2'd0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  control_packet_t      unit_control,
    output logic                 unit_ready,
    output logic                 unit_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [6:0]           mem_addr,
    input  logic                 mem_gnt,
    output logic                 compute_start,
    output logic [1:0]           compute_type,
    input  logic                 compute_done,
    output logic [CNT_W-1:0]     busy_cycles
);

    localparam int unsigned BEAT_W = 3;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TYPE_W = 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        XFER       = 3'd1,
        COMP_START = 3'd2,
        COMP_WAIT  = 3'd3,
        DONE       = 3'd4
    } state_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   size_q, size_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]    busy_q, busy_d;

    // Packet field decode
    logic [1:0]          pkt_id;
    op_e                 pkt_op;
    logic [TYPE_W-1:0]   pkt_type;
    logic [ADDR_W-1:0]   pkt_addr;
    logic                pkt_valid;
    logic [BEAT_W-1:0]   pkt_size;
    logic                accept;

    assign pkt_id    = unit_control.encoded_control[5:4];
    assign pkt_op    = op_e'(unit_control.encoded_control[3:2]);
    assign pkt_type  = unit_control.encoded_control[1:0];
    assign pkt_addr  = unit_control.data_control[7:4];
    assign pkt_valid = unit_control.data_control[3];
    assign pkt_size  = unit_control.data_control[2:0];
    assign accept    = (state_q == IDLE) && (pkt_id == UNIT_ID)
                       && (pkt_op != OP_NOP) && pkt_valid;

    // State and latched command registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            type_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            beat_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic and output decode from registered state
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        type_d        = type_q;
        addr_d        = addr_q;
        size_d        = size_q;
        beat_d        = beat_q;
        busy_d        = busy_q;
        unit_ready    = 1'b0;
        unit_done     = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        compute_start = 1'b0;
        compute_type  = '0;

        case (state_q)
            IDLE: begin
                unit_ready = 1'b1;
                if (accept) begin
                    op_d    = pkt_op;
                    type_d  = pkt_type;
                    addr_d  = pkt_addr;
                    size_d  = pkt_size;
                    beat_d  = '0;
                    busy_d  = CNT_W'(1);
                    state_d = (pkt_op == OP_COMPUTE) ? COMP_START : XFER;
                end
            end
            XFER: begin
                mem_req  = 1'b1;
                mem_we   = (op_q == OP_STORE);
                mem_addr = {addr_q, beat_q};
                if (mem_gnt) begin
                    if (beat_q == size_q) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            COMP_START: begin
                compute_start = 1'b1;
                state_d       = COMP_WAIT;
            end
            COMP_WAIT: begin
                if (compute_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                unit_done = 1'b1;
                if (pkt_op == OP_NOP) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            compute_type = type_q;
        end

        // The counter already includes the current cycle, so the exit cycle adds nothing
        if ((state_q == XFER || state_q == COMP_START || state_q == COMP_WAIT)
            && (state_d != DONE) && (busy_q != {CNT_W{1'b1}})) begin
            busy_d = busy_q + CNT_W'(1);
        end
    end

    assign busy_cycles = busy_q;

endmodule

// File: tb/tb_unit_responder.sv
// Self-checking bench for unit_responder: directed scenarios plus randomized commands
// checked against a queue-based transaction model.
module tb_unit_responder;
    import unit_responder_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    control_packet_t    unit_control;
    logic               unit_ready;
    logic               unit_done;
    logic               mem_req;
    logic               mem_we;
    logic [6:0]         mem_addr;
    logic               mem_gnt;
    logic               compute_start;
    logic [1:0]         compute_type;
    logic               compute_done;
    logic [CNT_W-1:0]   busy_cycles;

    int checks = 0;
    int errors = 0;
    int last_busy = 0;

    unit_responder #(.UNIT_ID(2'd1), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .unit_control  (unit_control),
        .unit_ready    (unit_ready),
        .unit_done     (unit_done),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .compute_start (compute_start),
        .compute_type  (compute_type),
        .compute_done  (compute_done),
        .busy_cycles   (busy_cycles)
    );

    always #5 clk = ~clk;

    function automatic control_packet_t pkt(input logic [1:0] id, input logic [1:0] op,
                                            input logic [1:0] typ, input logic [3:0] addr,
                                            input logic v, input logic [2:0] size);
        control_packet_t p;
        p.encoded_control = {id, op, typ};
        p.data_control    = {addr, v, size};
        return p;
    endfunction

    function automatic control_packet_t junk_cmd();
        return pkt(2'($urandom), 2'($urandom_range(1, 3)), 2'($urandom), 4'($urandom),
                   1'($urandom), 3'($urandom));
    endfunction

    task automatic test_reset;
        rst_n        = 1'b0;
        unit_control = pkt(2'd1, 2'b01, 2'b00, 4'h5, 1'b1, 3'd3);
        mem_gnt      = 1'b0;
        compute_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({unit_ready, unit_done, mem_req, mem_we, mem_addr, compute_start, compute_type}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b done=%b req=%b we=%b addr=%h cs=%b ct=%b want 1 0 0 0 00 0 00",
                     unit_ready, unit_done, mem_req, mem_we, mem_addr, compute_start, compute_type);
        end
        checks++;
        if (busy_cycles !== '0) begin
            errors++;
            $display("FAIL reset_busy got %0d want 0", busy_cycles);
        end
        unit_control = pkt(2'd1, 2'b00, 2'b00, 4'h0, 1'b0, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        last_busy = 0;
    endtask

    // gmode: 0 grant always, 1 random grant, 2 grant withheld for the first 4 cycles
    task automatic run_xfer(input logic st, input logic [3:0] addr, input logic [2:0] size,
                            input int gmode, input int exp_busy);
        int q[$];
        int cyc;
        int guard;
        cyc = 0;
        guard = 0;
        for (int b = 0; b <= int'(size); b++) q.push_back(int'(addr) * 8 + b);
        checks++;
        if (unit_ready !== 1'b1) begin
            errors++;
            $display("FAIL xfer_ready_before got %b want 1", unit_ready);
        end
        unit_control = pkt(2'd1, st ? 2'b10 : 2'b01, 2'b00, addr, 1'b1, size);
        mem_gnt = 1'b0;
        @(negedge clk);
        unit_control = junk_cmd();
        while (q.size() > 0 && guard < 100) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== 7'(q[0])) begin
                errors++;
                $display("FAIL xfer_beat got req=%b we=%b addr=%h want 1 %b %h",
                         mem_req, mem_we, mem_addr, st, 7'(q[0]));
            end
            cyc++;
            case (gmode)
                0:       mem_gnt = 1'b1;
                2:       mem_gnt = (cyc > 4);
                default: mem_gnt = 1'($urandom);
            endcase
            if (mem_gnt) void'(q.pop_front());
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout got %0d beats left want 0", q.size());
        end
        mem_gnt = 1'($urandom);
        checks++;
        if (unit_done !== 1'b1 || mem_req !== 1'b0 || unit_ready !== 1'b0) begin
            errors++;
            $display("FAIL xfer_done got done=%b req=%b rdy=%b want 1 0 0", unit_done, mem_req, unit_ready);
        end
        checks++;
        if (busy_cycles !== CNT_W'(cyc)) begin
            errors++;
            $display("FAIL xfer_busy got %0d want %0d", busy_cycles, cyc);
        end
        if (exp_busy >= 0) begin
            checks++;
            if (busy_cycles !== CNT_W'(exp_busy)) begin
                errors++;
                $display("FAIL xfer_busy_const got %0d want %0d", busy_cycles, exp_busy);
            end
        end
        last_busy = cyc;
    endtask

    task automatic run_comp(input logic [1:0] typ, input int d, input int exp_busy);
        checks++;
        if (unit_ready !== 1'b1) begin
            errors++;
            $display("FAIL comp_ready_before got %b want 1", unit_ready);
        end
        unit_control = pkt(2'd1, 2'b11, typ, 4'($urandom), 1'b1, 3'($urandom));
        compute_done = 1'($urandom);
        @(negedge clk);
        unit_control = junk_cmd();
        checks++;
        if (compute_start !== 1'b1 || compute_type !== typ || mem_req !== 1'b0 || busy_cycles !== CNT_W'(1)) begin
            errors++;
            $display("FAIL comp_start got cs=%b ct=%b req=%b busy=%0d want 1 %b 0 1",
                     compute_start, compute_type, mem_req, busy_cycles, typ);
        end
        compute_done = 1'($urandom);
        for (int j = 1; j <= d; j++) begin
            @(negedge clk);
            checks++;
            if (compute_start !== 1'b0 || unit_done !== 1'b0 || compute_type !== typ) begin
                errors++;
                $display("FAIL comp_wait got cs=%b done=%b ct=%b want 0 0 %b",
                         compute_start, unit_done, compute_type, typ);
            end
            compute_done = (j == d);
        end
        @(negedge clk);
        compute_done = 1'b0;
        checks++;
        if (unit_done !== 1'b1 || compute_type !== typ || busy_cycles !== CNT_W'(d + 1)) begin
            errors++;
            $display("FAIL comp_done got done=%b ct=%b busy=%0d want 1 %b %0d",
                     unit_done, compute_type, busy_cycles, typ, d + 1);
        end
        if (exp_busy >= 0) begin
            checks++;
            if (busy_cycles !== CNT_W'(exp_busy)) begin
                errors++;
                $display("FAIL comp_busy_const got %0d want %0d", busy_cycles, exp_busy);
            end
        end
        last_busy = d + 1;
    endtask

    // Hold a non-NOP packet for n cycles in DONE, then release with a NOP
    task automatic finish_cmd(input control_packet_t hp, input int n);
        mem_gnt = 1'b0;
        unit_control = hp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (unit_done !== 1'b1 || unit_ready !== 1'b0 || mem_req !== 1'b0
                || compute_start !== 1'b0 || busy_cycles !== CNT_W'(last_busy)) begin
                errors++;
                $display("FAIL done_hold got done=%b rdy=%b req=%b cs=%b busy=%0d want 1 0 0 0 %0d",
                         unit_done, unit_ready, mem_req, compute_start, busy_cycles, last_busy);
            end
        end
        unit_control = pkt(2'($urandom), 2'b00, 2'($urandom), 4'($urandom), 1'($urandom), 3'($urandom));
        @(negedge clk);
        checks++;
        if (unit_ready !== 1'b1 || unit_done !== 1'b0 || busy_cycles !== CNT_W'(last_busy)) begin
            errors++;
            $display("FAIL done_release got rdy=%b done=%b busy=%0d want 1 0 %0d",
                     unit_ready, unit_done, busy_cycles, last_busy);
        end
    endtask

    task automatic test_load;
        run_xfer(1'b0, 4'h3, 3'd2, 0, 3);
        finish_cmd(junk_cmd(), 0);
    endtask

    task automatic test_store_stall;
        run_xfer(1'b1, 4'($urandom), 3'd0, 2, 5);
        finish_cmd(junk_cmd(), 1);
    endtask

    task automatic test_compute;
        run_comp(2'b10, 6, 7);
        finish_cmd(junk_cmd(), 2);
    endtask

    task automatic test_ignored;
        control_packet_t ps[3];
        ps[0] = pkt(2'd2, 2'b01, 2'b00, 4'h4, 1'b1, 3'd1);
        ps[1] = pkt(2'd1, 2'b11, 2'b01, 4'h4, 1'b0, 3'd1);
        ps[2] = pkt(2'd1, 2'b00, 2'b00, 4'h4, 1'b1, 3'd1);
        for (int k = 0; k < 3; k++) begin
            unit_control = ps[k];
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (unit_ready !== 1'b1 || mem_req !== 1'b0 || compute_start !== 1'b0
                    || unit_done !== 1'b0 || busy_cycles !== CNT_W'(last_busy)) begin
                    errors++;
                    $display("FAIL ignored_%0d got rdy=%b req=%b cs=%b done=%b busy=%0d want 1 0 0 0 %0d",
                             k, unit_ready, mem_req, compute_start, unit_done, busy_cycles, last_busy);
                end
            end
        end
    endtask

    task automatic test_hold_done;
        logic [3:0] a;
        a = 4'($urandom);
        run_xfer(1'b0, a, 3'd1, 0, 2);
        finish_cmd(pkt(2'd1, 2'b01, 2'b00, a, 1'b1, 3'd1), 10);
    endtask

    task automatic test_reset_mid;
        logic [3:0] a;
        a = 4'($urandom);
        unit_control = pkt(2'd1, 2'b01, 2'b00, a, 1'b1, 3'd7);
        mem_gnt = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 7'(int'(a) * 8 + 2)) begin
            errors++;
            $display("FAIL rst_mid_beat2 got req=%b addr=%h want 1 %h", mem_req, mem_addr, 7'(int'(a) * 8 + 2));
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (unit_ready !== 1'b1 || mem_req !== 1'b0 || unit_done !== 1'b0 || mem_addr !== 7'h00
            || compute_type !== 2'b00 || busy_cycles !== '0) begin
            errors++;
            $display("FAIL rst_mid_after got rdy=%b req=%b done=%b addr=%h ct=%b busy=%0d want 1 0 0 00 00 0",
                     unit_ready, mem_req, unit_done, mem_addr, compute_type, busy_cycles);
        end
        unit_control = pkt(2'd1, 2'b00, 2'b00, 4'h0, 1'b0, 3'd0);
        mem_gnt = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (unit_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle got rdy=%b req=%b want 1 0", unit_ready, mem_req);
        end
        last_busy = 0;
        run_xfer(1'b1, 4'($urandom), 3'd3, 1, -1);
        finish_cmd(junk_cmd(), 1);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind < 2) begin
                run_xfer(1'(kind), 4'($urandom), 3'($urandom), 1, -1);
            end else begin
                run_comp(2'($urandom), int'($urandom_range(1, 9)), -1);
            end
            finish_cmd(junk_cmd(), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_stall();
        test_compute();
        test_ignored();
        test_hold_done();
        test_reset_mid();
        test_random(25);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unit_responder.md
UNIT_RESPONDER -- requirements
Module: unit_responder

Interface
REQ-001 SHALL have parameter UNIT_ID, default 0, 2-bit ID this unit answers to.
REQ-002 SHALL have parameter CNT_W, default 16, width of busy_cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port unit_control  input  control_packet_t  command from controller.
- encoded_control[5:4] = unit ID; [3:2] = op (00 NOP, 01 LOAD, 10 STORE, 11 COMPUTE); [1:0] = compute type.
- data_control[7:4] = base addr; [3] = valid; [2:0] = size.
REQ-006 SHALL have port unit_ready  output  1  unit idle and able to accept a command.
REQ-007 SHALL have port unit_done  output  1  command complete; held until NOP is seen.
REQ-008 SHALL have port mem_req  output  1  memory beat request.
REQ-009 SHALL have port mem_we  output  1  1 = write (STORE), 0 = read (LOAD).
REQ-010 SHALL have port mem_addr  output  7  word address {base addr, beat[2:0]}.
REQ-011 SHALL have port mem_gnt  input  1  memory accepts the current beat.
REQ-012 SHALL have port compute_start  output  1  one-cycle compute launch pulse.
REQ-013 SHALL have port compute_type  output  2  latched compute type.
REQ-014 SHALL have port compute_done  input  1  compute engine finished.
REQ-015 SHALL have port busy_cycles  output  CNT_W  cycle count of the last or current command.

Function
REQ-016 SHALL implement states IDLE, XFER, COMP_START, COMP_WAIT, DONE.
REQ-017 SHALL define accept as: state IDLE, ID == UNIT_ID, op != NOP, valid == 1.
- On accept, latch op, type, addr and size.
- Non-matching ID, or valid == 0: ignored; stay IDLE.
REQ-018 SHALL leave IDLE on accept, one cycle after the packet is sampled.
- LOAD/STORE -> XFER with beat = 0.
- COMPUTE -> COMP_START.
REQ-019 SHALL drive unit_ready = (state == IDLE), combinationally from the state register.
REQ-020 SHALL drive, in XFER: mem_req = 1, mem_we = (op == STORE), mem_addr = {addr, beat}.
REQ-021 SHALL hold mem_req, mem_we and mem_addr stable until mem_gnt is 1 in the same cycle.
REQ-022 SHALL, on mem_req & mem_gnt: if beat == size, go to DONE; otherwise beat++.
- Total beats = size + 1 (1..8); beat never wraps.
REQ-023 SHALL, in COMP_START, pulse compute_start for exactly one cycle, then go to COMP_WAIT.
REQ-024 SHALL drive compute_type from the latched value whenever state != IDLE.
REQ-025 SHALL sample compute_done only in COMP_WAIT; compute_done = 1 -> DONE.
- compute_done in any other state is ignored.
REQ-026 SHALL assert unit_done = 1 in DONE.
- DONE -> IDLE in the first cycle the incoming op == NOP, with any ID.
- Otherwise DONE holds; a stale command is never re-executed.
REQ-027 SHALL ignore packet changes outside IDLE; there is no abort path.
REQ-028 SHALL set busy_cycles to 1 on accept.
- Increments by 1 each cycle in XFER, COMP_START and COMP_WAIT.
- Saturates at all-ones; holds value in DONE and IDLE.
REQ-029 SHALL drive mem_req = 0 outside XFER and compute_start = 0 outside COMP_START.
REQ-030 SHALL use no combinational path from inputs to outputs; all outputs are decoded from registers.

Reset
REQ-031 SHALL, on a clock edge with rst_n = 0 in any state, force:
- state IDLE, beat 0, all latched fields 0, busy_cycles 0.
REQ-032 SHALL, after reset, present: unit_ready = 1, unit_done = 0, mem_req = 0, mem_we = 0, mem_addr = 0, compute_start = 0, compute_type = 0.
REQ-033 SHALL drop a transfer or compute interrupted by reset; no further beat or pulse is issued.

Verification
REQ-034 SHALL verify LOAD with UNIT_ID = 1, packet {01, 01, 00}/{0x3, 1, 010}, mem_gnt always 1:
- Addresses 0x18, 0x19, 0x1A with mem_we = 0.
- unit_done next cycle; busy_cycles = 3; IDLE one cycle after NOP.
REQ-035 SHALL verify STORE, size 0, mem_gnt low for 4 cycles:
- mem_req and mem_addr held steady for 5 cycles with mem_we = 1; exactly one beat; then DONE.
REQ-036 SHALL verify COMPUTE, type 10, compute_done 6 cycles after the start pulse:
- One compute_start pulse; compute_type = 10; unit_done after done; busy_cycles = 7.
REQ-037 SHALL verify that wrong ID, valid = 0, or a NOP packet each cause no state change and no mem_req.
REQ-038 SHALL verify that holding the same non-NOP packet 10 cycles in DONE:
- Keeps unit_done = 1 and does not start a second command.
REQ-039 SHALL verify that rst_n low during beat 2 of an 8-beat LOAD:
- Returns to IDLE with mem_req = 0 next cycle; a new command then executes normally.
